// File: rtl/ps2_event_decoder.sv
// -----------------------------------------------------------------------------
// ps2_event_decoder
//
// Folds raw PS/2 Set-2 scan bytes into single key events and queues them in a
// small first-word-fall-through FIFO for the CPU to poll.
//   - E0 prefix marks an extended key, F0 marks a release, E1 starts the
//     8-byte pause sequence, which is collapsed into one {ext=1, code=E1} event.
//   - Status/ack bytes and the E0,12 / E0,F0,12 "fake shift" bytes are dropped.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   kd, kv    raw scan byte and its one-cycle strobe
//   ev_code   key code of the head event (0 when empty)
//   ev_ext    head event carried the E0 prefix
//   ev_brk    head event is a release
//   ev_valid  FIFO non-empty
//   ev_ready  consumer pops the head when ev_valid is also high
//   ovf       sticky: an event was dropped because the FIFO was full
//   ovf_clr   clears ovf (a simultaneous drop wins)
//   count     number of events held
// -----------------------------------------------------------------------------
module ps2_event_decoder #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    kd,
   input  logic          kv,
   output logic [7:0]    ev_code,
   output logic          ev_ext,
   output logic          ev_brk,
   output logic          ev_valid,
   input  logic          ev_ready,
   output logic          ovf,
   input  logic          ovf_clr,
   output logic [AW:0]   count
);

   localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_E0,
      S_F0,
      S_E0F0,
      S_SKIP
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [2:0]    r_skip;
   logic [2:0]    w_skip_nxt;
   logic          w_push;
   logic [9:0]    w_word;

   logic [9:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_ovf;

   logic          w_pop;
   logic          w_full;
   logic          w_wr_en;
   logic          w_drop;
   logic [9:0]    w_head;

   // Bytes the keyboard sends as status/acknowledge rather than key data.
   function automatic logic f_is_status(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA,
         8'hFC, 8'hFD, 8'hFE, 8'hFF: f_is_status = 1'b1;
         default:                    f_is_status = 1'b0;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Decoder FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_skip  <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_skip  <= w_skip_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Decoder FSM: next state and event push
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_skip_nxt  = r_skip;
      w_push      = 1'b0;
      w_word      = 10'd0;
      if (kv) begin
         case (r_state)
            S_IDLE: begin
               if (kd == 8'hE0) begin
                  w_state_nxt = S_E0;
               end else if (kd == 8'hF0) begin
                  w_state_nxt = S_F0;
               end else if (kd == 8'hE1) begin
                  w_state_nxt = S_SKIP;
                  w_skip_nxt  = 3'd7;
               end else if (!f_is_status(kd)) begin
                  w_push = 1'b1;
                  w_word = {2'b00, kd};
               end
            end
            S_E0: begin
               if (kd == 8'hF0) begin
                  w_state_nxt = S_E0F0;
               end else if (kd == 8'hE0) begin
                  w_state_nxt = S_E0;
               end else begin
                  // E0,12 is the fake shift the keyboard wraps around some keys.
                  w_state_nxt = S_IDLE;
                  if (kd != 8'h12) begin
                     w_push = 1'b1;
                     w_word = {2'b10, kd};
                  end
               end
            end
            S_F0: begin
               w_state_nxt = S_IDLE;
               w_push      = 1'b1;
               w_word      = {2'b01, kd};
            end
            S_E0F0: begin
               w_state_nxt = S_IDLE;
               if (kd != 8'h12) begin
                  w_push = 1'b1;
                  w_word = {2'b11, kd};
               end
            end
            S_SKIP: begin
               // Pause: swallow the remaining 7 bytes, emit one event on the last.
               w_skip_nxt = r_skip - 3'd1;
               if (r_skip == 3'd1) begin
                  w_state_nxt = S_IDLE;
                  w_push      = 1'b1;
                  w_word      = {2'b10, 8'hE1};
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_skip_nxt  = 3'd0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Event FIFO
   // ---------------------------------------------------------------------------
   assign w_pop   = (r_count != '0) && ev_ready;
   assign w_full  = (r_count == LP_FULL);
   // A push into a full FIFO is still accepted when the head leaves this cycle.
   assign w_wr_en = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr_en && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (w_pop && !w_wr_en) begin
            r_count <= r_count - (AW+1)'(1);
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (ovf_clr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // Head fields are forced to 0 while empty so they read 0 straight out of reset
   // without having to reset the storage array.
   assign w_head   = (r_count != '0) ? r_mem[r_rd_ptr] : 10'd0;
   assign ev_ext   = w_head[9];
   assign ev_brk   = w_head[8];
   assign ev_code  = w_head[7:0];
   assign ev_valid = (r_count != '0);
   assign ovf      = r_ovf;
   assign count    = r_count;

endmodule

// File: tb/tb_ps2_event_decoder.sv
module tb_ps2_event_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] kd;
   logic       kv;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_brk;
   logic       ev_valid;
   logic       ev_ready;
   logic       ovf;
   logic       ovf_clr;
   logic [3:0] count;

   int n_checks = 0;
   int n_errors = 0;

   ps2_event_decoder #(.DEPTH(8), .AW(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .kd       (kd),
      .kv       (kv),
      .ev_code  (ev_code),
      .ev_ext   (ev_ext),
      .ev_brk   (ev_brk),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] head();
      return {22'd0, ev_ext, ev_brk, ev_code};
   endfunction

   // Drive on the falling edge; outputs are sampled on the falling edge too.
   task automatic send_byte(input logic [7:0] b);
      kd = b;
      kv = 1'b1;
      @(negedge clk);
      kv = 1'b0;
   endtask

   task automatic pop();
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   logic [7:0] exp_q [$];
   logic [7:0] e;

   initial begin
      rst_n = 1'b0; kd = 8'h00; kv = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
      @(negedge clk);
      check("rst_count", count, 0);
      check("rst_valid", ev_valid, 0);
      check("rst_ovf", ovf, 0);
      check("rst_head", head(), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single make code and pop
      send_byte(8'h1C);
      check("t1_valid", ev_valid, 1);
      check("t1_head", head(), 10'h01C);
      check("t1_count", count, 1);
      pop();
      check("t1_valid_after_pop", ev_valid, 0);
      check("t1_count_after_pop", count, 0);

      // Prefix folding and filtering
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'h12);
      send_byte(8'hFA);
      check("t2_count", count, 3);
      check("t2_ev0", head(), 10'h11C); pop();
      check("t2_ev1", head(), 10'h275); pop();
      check("t2_ev2", head(), 10'h375); pop();
      check("t2_empty", count, 0);

      // Pause sequence collapses to one event on the 8th byte
      send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
      send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
      check("t3_count_7bytes", count, 0);
      send_byte(8'h77);
      check("t3_count", count, 1);
      check("t3_ev", head(), 10'h2E1);
      pop();
      send_byte(8'h1C);
      check("t3_idle_after", head(), 10'h01C);
      pop();

      // Empty FIFO: push with ev_ready high is not bypassed
      kd = 8'h33; kv = 1'b1; ev_ready = 1'b1;
      @(negedge clk);
      kv = 1'b0; ev_ready = 1'b0;
      check("t4_nobypass_count", count, 1);
      check("t4_nobypass_head", head(), 10'h033);
      pop();

      // Overflow with ev_ready low
      for (int i = 0; i < 8; i++) send_byte(8'h15 + 8'(i));
      check("t5_full_no_ovf", ovf, 0);
      send_byte(8'h1D);
      check("t5_count", count, 8);
      check("t5_ovf", ovf, 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t5_drain%0d", i), head(), {24'd0, 8'h15 + 8'(i)});
         pop();
      end
      check("t5_drained", count, 0);
      check("t5_ovf_sticky", ovf, 1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("t5_ovf_clr", ovf, 0);

      // Full FIFO with simultaneous pop accepts the push
      for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i));
      kd = 8'h2A; kv = 1'b1; ev_ready = 1'b1;
      @(negedge clk);
      kv = 1'b0; ev_ready = 1'b0;
      check("t6_count", count, 8);
      check("t6_ovf", ovf, 0);
      for (int i = 1; i < 8; i++) begin
         check($sformatf("t6_drain%0d", i), head(), {24'd0, 8'h20 + 8'(i)});
         pop();
      end
      check("t6_last", head(), 10'h02A);
      pop();
      check("t6_empty", count, 0);

      // Many events across pointer wrap, in bursts of five
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 5; j++) begin
            e = 8'h30 + 8'(r * 5 + j);
            exp_q.push_back(e);
            send_byte(e);
         end
         check($sformatf("t7_count_r%0d", r), count, 5);
         for (int j = 0; j < 5; j++) begin
            e = exp_q.pop_front();
            check($sformatf("t7_r%0d_e%0d", r, j), head(), {24'd0, e});
            pop();
         end
      end
      check("t7_empty", count, 0);

      // Asynchronous reset mid-prefix with a full FIFO and ovf set
      for (int i = 0; i < 9; i++) send_byte(8'h50 + 8'(i));
      check("t8_pre_ovf", ovf, 1);
      send_byte(8'hE0);
      #3;
      rst_n = 1'b0;
      #1;
      check("t8_async_count", count, 0);
      check("t8_async_ovf", ovf, 0);
      check("t8_async_valid", ev_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_byte(8'h75);
      check("t8_prefix_discarded", head(), 10'h075);
      check("t8_count", count, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ps2_event_decoder.md
Name: ps2_event_decoder

Overview:
- Sits between the PS/2 keyboard receiver and the CPU, in the `clk` domain (the pixel/system clock).
- Consumes raw scan-code bytes (`kd`, qualified by a one-cycle `kv` strobe).
- Folds the Set-2 prefixes E0 (extended), F0 (break) and E1 (pause) into single key events.
- Buffers events in a small first-word-fall-through FIFO with a valid/ready handshake, so the CPU can poll at its own pace without losing keystrokes.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, 3, FIFO address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low; release is synchronised externally.
- kd  in  8  raw scan byte from the keyboard receiver.
- kv  in  1  one-cycle strobe; `kd` is valid while high.
- ev_code  out  8  key code of the head event.
- ev_ext  out  1  head event carried the E0 prefix.
- ev_brk  out  1  head event is a release (F0 seen).
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts the head event when `ev_valid` and `ev_ready` are both high.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears `ovf`.
- count  out  AW+1  number of events held.

Behaviour:
- Reset (`rst_n` low, asynchronous): FSM returns to IDLE, skip counter = 0, FIFO pointers = 0, `count` = 0, `ev_valid` = 0, `ovf` = 0. `ev_code`/`ev_ext`/`ev_brk` read 0. Reset mid-sequence discards any partial prefix.
- Bytes are processed only on cycles where `kv` = 1. Other cycles leave the FSM unchanged.
- Decoder FSM states: IDLE, E0, F0, E0F0, SKIP.
- IDLE:
  - E0 -> E0.
  - F0 -> F0.
  - E1 -> SKIP with skip = 7.
  - 00, AA, EE, FA, FC, FD, FE, FF -> dropped (status/ack bytes), stay IDLE.
  - Any other byte b -> push {ext=0, brk=0, code=b}, stay IDLE.
- E0:
  - F0 -> E0F0.
  - 12 -> dropped (fake shift), back to IDLE.
  - E0 -> stay E0.
  - Other b -> push {1,0,b}, IDLE.
- F0:
  - Any b -> push {0,1,b}, IDLE. No filtering in this state.
- E0F0:
  - 12 -> dropped, IDLE.
  - Other b -> push {1,1,b}, IDLE.
- SKIP:
  - Each byte decrements skip.
  - The byte that takes skip 1 -> 0 causes push {1,0,E1}, then IDLE.
  - The pause key therefore yields exactly one event.
- Push latency: the event is written at the clock edge ending the `kv` cycle. `ev_valid` and the head fields reflect it from the next cycle. No combinational path from `kd` to outputs.
- FIFO:
  - Word = {ext, brk, code}, 10 bits.
  - Head fields are driven from the entry at the read pointer, and are stable while `ev_valid` = 1 and no pop occurs.
  - Pop = `ev_valid` & `ev_ready`; the read pointer advances at that edge. `ev_ready` with an empty FIFO has no effect.
  - Pointers wrap modulo DEPTH.
  - `count` increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
- Full boundary:
  - Push with `count` == DEPTH and no pop in the same cycle: event dropped, FIFO unchanged, `ovf` set at that edge.
  - Push with `count` == DEPTH and a simultaneous pop: accepted, `count` stays DEPTH, `ovf` not set.
- Empty boundary: push with `count` == 0 and `ev_ready` = 1 is not bypassed. The event appears the following cycle.
- `ovf_clr`: clears `ovf` at the edge. If a drop coincides with `ovf_clr`, set wins and `ovf` = 1.

Test Plan:
- Reset then `kv` pulses with `kd` = 1C -> one cycle later `ev_valid` = 1, {ext,brk,code} = {0,0,1C}, `count` = 1. `ev_ready` = 1 for one cycle -> `ev_valid` = 0, `count` = 0.
- Byte sequence F0,1C / E0,75 / E0,F0,75 / E0,12 / FA -> exactly three events in order: {0,1,1C}, {1,0,75}, {1,1,75}. `count` = 3.
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> single event {1,0,E1}, pushed on the 8th byte. FSM back in IDLE, verified by a following 1C giving {0,0,1C}.
- Nine make codes 15..1D with `ev_ready` = 0 and DEPTH = 8 -> `count` = 8, `ovf` = 1, drained order is 15..1C (1D lost). `ovf_clr` pulse -> `ovf` = 0.
- FIFO full with `ev_ready` = 1 held while a new byte 2A arrives -> `count` stays 8, `ovf` = 0, 2A becomes the last entry. Drain 20+ events across pointer wrap with no reordering.
- Assert `rst_n` low between E0 and 75 -> after release, 75 produces {0,0,75}. `count`, `ovf` and `ev_valid` are 0 immediately on assertion, without waiting for a clock edge.
